// File: rtl/div_iter_if.sv
// div_iter_if: handshake/result bundle for the iterative divider.
//   master : operand producer / result consumer (drives flush, in_*, out_ready)
//   slave  : divider (drives in_ready, out_valid, out_quotient, out_remainder, busy)
// Signals:
//   flush         cancel the in-flight operation
//   in_valid      operands valid            in_ready      divider can accept
//   in_signed     1 = signed divide         in_dividend   dividend
//   in_divisor    divisor
//   out_valid     result valid              out_ready     consumer takes result
//   out_quotient  quotient                  out_remainder remainder
//   busy          divider not idle
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quotient;
  logic [WIDTH-1:0] out_remainder;
  logic             busy;

  modport master (
    output flush, in_valid, in_signed, in_dividend, in_divisor, out_ready,
    input  in_ready, out_valid, out_quotient, out_remainder, busy
  );

  modport slave (
    input  flush, in_valid, in_signed, in_dividend, in_divisor, out_ready,
    output in_ready, out_valid, out_quotient, out_remainder, busy
  );
endinterface

// File: rtl/div_iter.sv
// div_iter: multi-cycle radix-2 restoring divider (signed/unsigned) producing
// quotient and remainder, with valid/ready on both sides and flush.
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    div_iter_if.slave (operands, result, flush, busy)
// Optional build macro:
//   DIV_ZERO_FAST_EN  when defined, a zero divisor skips the iterations and the
//                     result appears one cycle after accept.
// Divide by zero yields quotient = all ones, remainder = raw dividend.
module div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic      clk,
  input  logic      reset,
  div_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t r_state, w_state_nxt, w_start_state;

  logic             w_in_ready, w_accept, w_step, w_last;
  logic             w_sa, w_sb, w_div0_in;
  logic [WIDTH-1:0] w_dvd_mag, w_dsr_mag;

  // Partial remainder kept one bit narrow: before any shift it is bounded by
  // the dividend bits consumed so far (at most WIDTH-1 of them), so its MSB
  // would always be zero. The full-width remainder only exists on the final step.
  logic [WIDTH-2:0] r_rem;
  logic [WIDTH-1:0] r_dvd, r_dsr, r_raw, r_quo, r_remo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sign_q, r_sign_r, r_div0;

  logic [WIDTH-1:0] w_rem_sh, w_rem_nxt, w_dvd_nxt, w_q_fix, w_r_fix;
  logic [WIDTH:0]   w_trial;

  // Operand conditioning
  always_comb begin
    w_sa      = bus.in_signed & bus.in_dividend[WIDTH-1];
    w_sb      = bus.in_signed & bus.in_divisor[WIDTH-1];
    w_dvd_mag = w_sa ? -bus.in_dividend : bus.in_dividend;
    w_dsr_mag = w_sb ? -bus.in_divisor  : bus.in_divisor;
    w_div0_in = (bus.in_divisor == '0);
  end

  // One restoring step; trial subtraction in WIDTH+1 bits, sign bit = borrow
  always_comb begin
    w_rem_sh  = {r_rem, r_dvd[WIDTH-1]};
    w_trial   = {1'b0, w_rem_sh} - {1'b0, r_dsr};
    w_rem_nxt = w_trial[WIDTH] ? w_rem_sh : w_trial[WIDTH-1:0];
    w_dvd_nxt = {r_dvd[WIDTH-2:0], ~w_trial[WIDTH]};
    w_q_fix   = r_div0 ? '1    : (r_sign_q ? -w_dvd_nxt : w_dvd_nxt);
    w_r_fix   = r_div0 ? r_raw : (r_sign_r ? -w_rem_nxt : w_rem_nxt);
  end

  // Next-state and handshake
  always_comb begin
    w_in_ready = !bus.flush && (r_state == IDLE || (r_state == DONE && bus.out_ready));
    w_accept   = bus.in_valid && w_in_ready;
    w_step     = (r_state == CALC) && !bus.flush;
    w_last     = w_step && (r_cnt == CNT_W'(1));
`ifdef DIV_ZERO_FAST_EN
    w_start_state = w_div0_in ? DONE : CALC;
`else
    w_start_state = CALC;
`endif
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (w_accept) w_state_nxt = w_start_state;
        CALC:    if (w_last)   w_state_nxt = DONE;
        DONE:    if (bus.out_ready) w_state_nxt = w_accept ? w_start_state : IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_raw    <= '0;
      r_quo    <= '0;
      r_remo   <= '0;
      r_cnt    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_div0   <= 1'b0;
    end else if (w_accept) begin
      r_rem    <= '0;
      r_dvd    <= w_dvd_mag;
      r_dsr    <= w_dsr_mag;
      r_raw    <= bus.in_dividend;
      r_cnt    <= CNT_W'(WIDTH);
      r_sign_q <= w_sa ^ w_sb;
      r_sign_r <= w_sa;
      r_div0   <= w_div0_in;
`ifdef DIV_ZERO_FAST_EN
      if (w_div0_in) begin
        r_quo  <= '1;
        r_remo <= bus.in_dividend;
        r_cnt  <= '0;
      end
`endif
    end else if (w_step) begin
      r_rem <= w_rem_nxt[WIDTH-2:0];
      r_dvd <= w_dvd_nxt;
      r_cnt <= r_cnt - 1'b1;
      if (w_last) begin
        r_quo  <= w_q_fix;
        r_remo <= w_r_fix;
      end
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = (r_state == DONE);
  assign bus.busy          = (r_state != IDLE);
  assign bus.out_quotient  = r_quo;
  assign bus.out_remainder = r_remo;

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed self-checking bench for div_iter (WIDTH=32).
// A cycle-level reference model (plain arithmetic division plus a due-cycle
// timer) is compared with the DUT on every clock; directed scenarios add
// hand-computed literal expectations.
module tb_div_iter;
  localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = W + 1;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  div_iter_if #(.WIDTH(W)) bus ();
  div_iter #(.WIDTH(W)) u_dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
  endfunction

  // Reference model: one operation in flight, result due a fixed number of
  // cycles after acceptance, outputs hold the last delivered result.
  bit          m_init = 0, m_have = 0;
  int          m_due  = 0;
  logic [31:0] m_q, m_r, m_outq = '0, m_outr = '0;
  logic        e_valid, e_ready;

  always @(negedge clk) begin
    if (m_init) begin
      if (m_have && cyc == m_due) begin
        m_outq = m_q;
        m_outr = m_r;
      end
      e_valid = m_have && (cyc >= m_due);
      e_ready = !bus.flush && (!m_have || (e_valid && bus.out_ready));
      chk("m_out_valid", {31'd0, bus.out_valid}, {31'd0, e_valid});
      chk("m_in_ready",  {31'd0, bus.in_ready},  {31'd0, e_ready});
      chk("m_busy",      {31'd0, bus.busy},      {31'd0, m_have});
      chk("m_quotient",  bus.out_quotient,  m_outq);
      chk("m_remainder", bus.out_remainder, m_outr);
    end
    if (reset) begin
      m_init = 1;
      m_have = 0;
      m_outq = '0;
      m_outr = '0;
    end else if (m_init) begin
      if (bus.flush) begin
        m_have = 0;
      end else begin
        if (e_valid && bus.out_ready) m_have = 0;
        if (bus.in_valid && e_ready) begin
          m_have = 1;
          m_due  = cyc + ((bus.in_divisor == 32'd0) ? DIV0_LAT : W + 1);
          model_div(bus.in_signed, bus.in_dividend, bus.in_divisor, m_q, m_r);
        end
      end
    end
  end

  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output int acc);
    int k;
    @(posedge clk); #1;
    bus.in_valid    = 1'b1;
    bus.in_signed   = sgn;
    bus.in_dividend = a;
    bus.in_divisor  = b;
    k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) chk("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
    acc = cyc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input int acc, input int lat, input logic [31:0] q,
                             input logic [31:0] r, input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!bus.out_valid) begin
      chk({name, "_timeout"}, {31'd0, bus.out_valid}, 32'd1);
    end else begin
      chk({name, "_lat"}, 32'(cyc - acc), 32'(lat));
      chk({name, "_q"}, bus.out_quotient, q);
      chk({name, "_r"}, bus.out_remainder, r);
    end
  endtask

  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r, input int lat,
                        input string name);
    int acc;
    start_op(sgn, a, b, acc);
    wait_result(acc, lat, q, r, name);
  endtask

  initial begin
    logic [31:0] pq, pr;
    int acc;
    bus.flush       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_signed   = 1'b0;
    bus.in_dividend = '0;
    bus.in_divisor  = '0;
    bus.out_ready   = 1'b1;

    // Pin the reference model to hand-computed values
    model_div(1'b1, 32'hFFFF_FFF9, 32'h2, pq, pr);
    chk("pin_m7_2_q", pq, 32'hFFFF_FFFD);  chk("pin_m7_2_r", pr, 32'hFFFF_FFFF);
    model_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, pq, pr);
    chk("pin_ovf_q", pq, 32'h8000_0000);   chk("pin_ovf_r", pr, 32'h0);
    model_div(1'b0, 32'd5, 32'd0, pq, pr);
    chk("pin_div0_q", pq, 32'hFFFF_FFFF);  chk("pin_div0_r", pr, 32'd5);
    model_div(1'b0, 32'd100, 32'd7, pq, pr);
    chk("pin_u100_7_q", pq, 32'd14);       chk("pin_u100_7_r", pr, 32'd2);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, bus.busy},      32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_q",         bus.out_quotient,       32'd0);
    chk("rst_r",         bus.out_remainder,      32'd0);

    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, W + 1, "u100_7");
    @(negedge clk);
    chk("u100_7_ready_after", {31'd0, bus.in_ready},  32'd1);
    chk("u100_7_valid_after", {31'd0, bus.out_valid}, 32'd0);

    run_op(1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, W + 1, "s_m7_2");
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, W + 1, "s_7_m2");
    run_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, W + 1, "s_m100_m7");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, W + 1, "s_ovf");
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, W + 1, "u_max_1");
    run_op(1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE, W + 1, "u_bigdiv");
    run_op(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, DIV0_LAT, "u_div0");
    run_op(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, DIV0_LAT, "s_div0");
    run_op(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, DIV0_LAT, "s_m5_div0");

    // Backpressure: hold result 5 cycles, then back-to-back accept
    @(posedge clk); #1 bus.out_ready = 1'b0;
    run_op(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, W + 1, "hold");
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid",    {31'd0, bus.out_valid}, 32'd1);
      chk("hold_q",        bus.out_quotient,       32'd333);
      chk("hold_r",        bus.out_remainder,      32'd1);
      chk("hold_in_ready", {31'd0, bus.in_ready},  32'd0);
    end
    @(posedge clk); #1;
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_signed   = 1'b0;
    bus.in_dividend = 32'd200;
    bus.in_divisor  = 32'd10;
    @(negedge clk);
    chk("b2b_in_ready", {31'd0, bus.in_ready}, 32'd1);
    acc = cyc;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    chk("b2b_busy",       {31'd0, bus.busy},      32'd1);
    wait_result(acc, W + 1, 32'd20, 32'd0, "b2b");

    // Flush on the 10th CALC cycle, operand waiting during the flush
    start_op(1'b0, 32'd1234, 32'd5, acc);
    repeat (9) begin
      @(negedge clk);
      chk("flush_no_valid", {31'd0, bus.out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    bus.flush       = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_signed   = 1'b0;
    bus.in_dividend = 32'd50;
    bus.in_divisor  = 32'd5;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, bus.in_ready},  32'd0);
    chk("flush_valid",    {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk); #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("post_flush_busy",  {31'd0, bus.busy},     32'd0);
    chk("post_flush_ready", {31'd0, bus.in_ready}, 32'd1);
    acc = cyc;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    wait_result(acc, W + 1, 32'd10, 32'd0, "post_flush");

    // Flush discards a waiting result
    @(posedge clk); #1 bus.out_ready = 1'b0;
    run_op(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, W + 1, "done_flush");
    @(posedge clk); #1 bus.flush = 1'b1;
    @(negedge clk);
    chk("done_flush_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("done_flush_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("done_flush_busy",  {31'd0, bus.busy},      32'd0);

    // Reset in the middle of CALC
    start_op(1'b1, 32'hFFFF_FC18, 32'd7, acc);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid",    {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_busy",     {31'd0, bus.busy},      32'd0);
    chk("mid_rst_in_ready", {31'd0, bus.in_ready},  32'd1);
    chk("mid_rst_q",        bus.out_quotient,       32'd0);
    chk("mid_rst_r",        bus.out_remainder,      32'd0);
    repeat (40) begin
      @(negedge clk);
      chk("mid_rst_no_valid", {31'd0, bus.out_valid}, 32'd0);
    end

    run_op(1'b1, 32'hFFFF_FC18, 32'd7, 32'hFFFF_FF72, 32'hFFFF_FFFA, W + 1, "s_m1000_7");

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
